lsu_arbiter: RTL and testbench

- Shares the single LSU data port between two requesters: port 0 (pipeline MEM stage) and port 1 (debug/DMA master).
- Grants at most one access per cycle and drives the LSU command bus.
- Routes the LSU's registered load data back to the requester that issued the load.
- Core has fixed priority; a starvation counter guarantees port 1 forward progress.

---
 rtl/lsu_arbiter.sv | 117 +++++++++++
 tb/tb_lsu_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_arbiter
// Brief    : Two-port arbiter in front of the single LSU data port. Port 0
//            (pipeline MEM stage) has fixed priority; a wait counter forces a
//            port 1 (debug/DMA) grant after MAX_WAIT consecutive refusals.
//            Registered load data is routed back to the issuing port.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_p0_req,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic        i_p0_wren,
  input  logic [2:0]  i_p0_func3,
  output logic        o_p0_gnt,
  output logic        o_p0_stall,
  output logic        o_p0_rvalid,
  output logic [31:0] o_p0_rdata,
  input  logic        i_p1_req,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic        i_p1_wren,
  input  logic [2:0]  i_p1_func3,
  output logic        o_p1_gnt,
  output logic        o_p1_rvalid,
  output logic [31:0] o_p1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic        o_lsu_wren,
  output logic        o_lsu_rden,
  output logic [2:0]  o_lsu_func3,
  input  logic [31:0] i_lsu_ld_data
);

  localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             resp_vld_q, resp_vld_d;
  logic             resp_port_q, resp_port_d;

  logic w_forced;
  logic w_gnt0;
  logic w_gnt1;
  logic w_sel_wren;

  // Grant decision: forced p1 grant beats p0 priority; nothing granted in reset
  always_comb begin
    w_forced = (wait_cnt_q == C_MAX_WAIT) & i_p1_req;
    w_gnt1   = i_reset & (w_forced | (~i_p0_req & i_p1_req));
    w_gnt0   = i_reset & i_p0_req & ~w_forced;
  end

  // LSU command mux: granted port's fields, all zero when idle
  always_comb begin
    o_lsu_addr    = 32'd0;
    o_lsu_st_data = 32'd0;
    o_lsu_func3   = 3'd0;
    w_sel_wren    = 1'b0;
    if (w_gnt0) begin
      o_lsu_addr    = i_p0_addr;
      o_lsu_st_data = i_p0_wdata;
      o_lsu_func3   = i_p0_func3;
      w_sel_wren    = i_p0_wren;
    end else if (w_gnt1) begin
      o_lsu_addr    = i_p1_addr;
      o_lsu_st_data = i_p1_wdata;
      o_lsu_func3   = i_p1_func3;
      w_sel_wren    = i_p1_wren;
    end
    o_lsu_wren = (w_gnt0 | w_gnt1) & w_sel_wren;
    o_lsu_rden = (w_gnt0 | w_gnt1) & ~w_sel_wren;
  end

  // Handshake outputs and response routing; in-flight data is masked in reset
  always_comb begin
    o_p0_gnt    = w_gnt0;
    o_p1_gnt    = w_gnt1;
    o_p0_stall  = i_p0_req & ~w_gnt0;
    o_p0_rvalid = i_reset & resp_vld_q & ~resp_port_q;
    o_p1_rvalid = i_reset & resp_vld_q & resp_port_q;
    o_p0_rdata  = o_p0_rvalid ? i_lsu_ld_data : 32'd0;
    o_p1_rdata  = o_p1_rvalid ? i_lsu_ld_data : 32'd0;
  end

  // Next state: refusal counter and load-response tracking, cleared in reset
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    resp_vld_d  = 1'b0;
    resp_port_d = 1'b0;
    if (!i_reset) begin
      wait_cnt_d = '0;
    end else begin
      if (w_gnt1 || !i_p1_req) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != C_MAX_WAIT) begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
      resp_vld_d  = o_lsu_rden;
      resp_port_d = w_gnt1;
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    wait_cnt_q  <= wait_cnt_d;
    resp_vld_q  <= resp_vld_d;
    resp_port_q <= resp_port_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_arbiter
// Brief    : Self-checking bench for lsu_arbiter. A behavioural model tracks
//            the port 1 refusal streak and the pending load response, and the
//            full output bundle is compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_wren, p1_req, p1_wren;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, lsu_ld;
  logic [2:0]  p0_f3, p1_f3;
  logic        p0_gnt, p0_stall, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata, lsu_addr, lsu_st;
  logic        lsu_wren, lsu_rden;
  logic [2:0]  lsu_f3;

  int vectors = 0;
  int miscompares = 0;

  // Model state: consecutive p1 refusals and the load awaiting its response
  int unsigned m_refused = 0;
  bit          m_pend = 0;
  bit          m_pport = 0;
  logic [137:0] exp_vec;

  always #5 clk = ~clk;

  lsu_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_p0_req(p0_req), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .i_p0_wren(p0_wren), .i_p0_func3(p0_f3),
    .o_p0_gnt(p0_gnt), .o_p0_stall(p0_stall), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata),
    .i_p1_req(p1_req), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .i_p1_wren(p1_wren), .i_p1_func3(p1_f3),
    .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata),
    .o_lsu_addr(lsu_addr), .o_lsu_st_data(lsu_st), .o_lsu_wren(lsu_wren),
    .o_lsu_rden(lsu_rden), .o_lsu_func3(lsu_f3), .i_lsu_ld_data(lsu_ld)
  );

  function automatic logic [137:0] dut_vec();
    return {p0_gnt, p1_gnt, p0_stall, p0_rvalid, p1_rvalid, lsu_wren, lsu_rden,
            lsu_f3, lsu_addr, lsu_st, p0_rdata, p1_rdata};
  endfunction

  // Expected outputs for the current inputs, from the arbitration rules
  task automatic model_comb();
    bit live, forced, g0, g1, rv0, rv1, wr;
    logic [31:0] a, d;
    logic [2:0] f;
    live   = (rst_n === 1'b1);
    forced = (m_refused == MAX_WAIT) && p1_req;
    g1 = live && (forced || (!p0_req && p1_req));
    g0 = live && p0_req && !forced;
    a = 0; d = 0; f = 0; wr = 0;
    if (g0) begin a = p0_addr; d = p0_wdata; f = p0_f3; wr = p0_wren; end
    if (g1) begin a = p1_addr; d = p1_wdata; f = p1_f3; wr = p1_wren; end
    rv0 = live && m_pend && !m_pport;
    rv1 = live && m_pend && m_pport;
    exp_vec = {g0, g1, p0_req && !g0, rv0, rv1, (g0 || g1) && wr, (g0 || g1) && !wr,
               f, a, d, rv0 ? lsu_ld : 32'd0, rv1 ? lsu_ld : 32'd0};
  endtask

  // Advance the model across the clock edge, then the simulation itself
  task automatic advance();
    bit live, forced, g0, g1;
    live   = (rst_n === 1'b1);
    forced = (m_refused == MAX_WAIT) && p1_req;
    g1 = live && (forced || (!p0_req && p1_req));
    g0 = live && p0_req && !forced;
    if (!live) begin
      m_refused = 0; m_pend = 0; m_pport = 0;
    end else begin
      if (p1_req && !g1) m_refused = (m_refused < MAX_WAIT) ? m_refused + 1 : MAX_WAIT;
      else m_refused = 0;
      m_pend  = (g0 && !p0_wren) || (g1 && !p1_wren);
      m_pport = g1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input bit req, input bit wren, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3);
    p0_req = req; p0_wren = wren; p0_addr = addr; p0_wdata = wdata; p0_f3 = f3;
  endtask

  task automatic set_p1(input bit req, input bit wren, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3);
    p1_req = req; p1_wren = wren; p1_addr = addr; p1_wdata = wdata; p1_f3 = f3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_p0($urandom_range(0, 1), $urandom_range(0, 1), $urandom(), $urandom(), 3'($urandom()));
      set_p1(1'b1, 1'b0, $urandom(), $urandom(), 3'($urandom()));
      lsu_ld = $urandom();
      model_comb(); #2; vectors++;
      if (dut_vec() !== exp_vec)
        begin miscompares++; $display("FAIL reset_hold k=%0d got=%h exp=%h", k, dut_vec(), exp_vec); end
      advance();
    end
    rst_n = 1'b1;
    set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0); lsu_ld = 32'hA5A5_A5A5;
    model_comb(); #2; vectors++;
    if (dut_vec() !== exp_vec)
      begin miscompares++; $display("FAIL reset_exit got=%h exp=%h", dut_vec(), exp_vec); end
    advance();
  endtask

  task automatic test_single_load();
    set_p0(1, 0, 32'h0000_0010, $urandom(), 3'b010); set_p1(0, 0, 0, 0, 0);
    lsu_ld = $urandom();
    model_comb(); #2; vectors++;
    if (dut_vec() !== exp_vec || p0_gnt !== 1'b1 || lsu_rden !== 1'b1)
      begin miscompares++; $display("FAIL p0_load_grant got=%h exp=%h", dut_vec(), exp_vec); end
    advance();
    set_p0(0, 0, 0, 0, 0); lsu_ld = 32'hDEAD_BEEF;
    model_comb(); #2; vectors++;
    if (dut_vec() !== exp_vec || p0_rdata !== 32'hDEAD_BEEF || p1_rvalid !== 1'b0)
      begin miscompares++; $display("FAIL p0_load_resp got=%h exp=%h", dut_vec(), exp_vec); end
    advance();
  endtask

  task automatic test_p1_store();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_p1(1, 1, 32'h1000_0000, 32'h0000_00FF, 3'b010);
      else set_p1(0, 0, 0, 0, 0);
      lsu_ld = $urandom();
      model_comb(); #2; vectors++;
      if (dut_vec() !== exp_vec || p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0)
        begin miscompares++; $display("FAIL p1_store k=%0d got=%h exp=%h", k, dut_vec(), exp_vec); end
      advance();
    end
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 15; k++) begin
      set_p0(1, 0, $urandom(), $urandom(), 3'($urandom()));
      set_p1(1, $urandom_range(0, 1), $urandom(), $urandom(), 3'($urandom()));
      lsu_ld = $urandom();
      model_comb(); #2; vectors++;
      if (dut_vec() !== exp_vec || p1_gnt !== (k % 5 == 4) || p0_stall !== (k % 5 == 4))
        begin miscompares++; $display("FAIL starvation k=%0d got=%h exp=%h", k, dut_vec(), exp_vec); end
      advance();
    end
    set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
    lsu_ld = $urandom(); model_comb(); #2; advance();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      set_p0(k == 0, 0, 32'h40 + k, 0, 3'b010);
      set_p1(k == 1, 0, 32'h80 + k, 0, 3'b100);
      lsu_ld = 32'hD000_0000 + k;
      model_comb(); #2; vectors++;
      if (dut_vec() !== exp_vec || p0_rvalid !== (k == 1) || p1_rvalid !== (k == 2))
        begin miscompares++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, dut_vec(), exp_vec); end
      advance();
    end
  endtask

  task automatic test_reset_mid_load();
    for (int k = 0; k < 4; k++) begin
      rst_n = !(k == 1 || k == 2);
      set_p0(k < 3, 0, 32'h0000_0020, 0, 3'b010);
      set_p1(k == 1, 0, 32'h0000_0030, 0, 3'b010);
      lsu_ld = $urandom();
      model_comb(); #2; vectors++;
      if (dut_vec() !== exp_vec || (k > 0 && (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0)))
        begin miscompares++; $display("FAIL reset_mid_load k=%0d got=%h exp=%h", k, dut_vec(), exp_vec); end
      advance();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_withdraw();
    // p1 refused 3 times, drops for one cycle, then needs 4 fresh refusals
    for (int k = 0; k < 10; k++) begin
      set_p0(1, 1, $urandom(), $urandom(), 3'b010);
      set_p1(k != 3, 1, $urandom(), $urandom(), 3'b010);
      lsu_ld = $urandom();
      model_comb(); #2; vectors++;
      if (dut_vec() !== exp_vec || p1_gnt !== (k == 8))
        begin miscompares++; $display("FAIL withdraw k=%0d got=%h exp=%h", k, dut_vec(), exp_vec); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      set_p0($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom(), $urandom(), 3'($urandom()));
      set_p1($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom(), $urandom(), 3'($urandom()));
      lsu_ld = $urandom();
      model_comb(); #2; vectors++;
      if (dut_vec() !== exp_vec)
        begin miscompares++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), exp_vec); end
      advance();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0); lsu_ld = 0;
    advance();
    test_reset();
    test_single_load();
    test_p1_store();
    test_starvation();
    test_back_to_back();
    test_reset_mid_load();
    test_withdraw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
